rd_data_collect: RTL and testbench



---
 rtl/rd_data_collect.sv | 130 +++++++++++++
 tb/tb_rd_data_collect.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rd_data_collect.sv
`default_nettype none
// ============================================================================
//  Module   : rd_data_collect
//  Purpose  : Read-return stage behind the DDR2 controller. Tracks read words
//             still owed by the MIG, buffers returned words in a small
//             first-word-fall-through ring, hands them to the consumer with a
//             valid/ready handshake, and issues the rd_en credit that keeps
//             the controller from requesting more than the ring can hold.
//  Revision : 1.0  initial release
// ============================================================================
module rd_data_collect #(
    parameter int         DATA_WIDTH  = 64,
    parameter int         BURST_WORDS = 2,
    parameter int         DEPTH       = 16,
    parameter logic [2:0] READ_CMD    = 3'b001
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic                    phy_init_done,
    input  logic                    app_af_wren,
    input  logic [2:0]              app_af_cmd,
    input  logic                    rd_data_valid,
    input  logic [DATA_WIDTH-1:0]   rd_data_fifo_out,
    input  logic                    dout_rdy,
    output logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    dout_vd,
    output logic [$clog2(DEPTH):0]  outstanding,
    output logic                    ovf_err,
    output logic                    unexp_err
);

    // Pointer, counter and credit-sum widths. The credit sum carries one
    // extra bit so count + outstanding can never wrap before the compare.
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_SW = c_AW + 2;

    localparam logic [c_CW-1:0] c_DEPTH   = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_BURST   = c_CW'(BURST_WORDS);
    localparam logic [c_SW-1:0] c_LIMIT   = c_SW'(DEPTH - BURST_WORDS);

    // Ring storage and its bookkeeping.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]       r_wr_ptr;
    logic [c_AW-1:0]       r_rd_ptr;
    logic [c_CW-1:0]       r_count;
    logic [c_CW-1:0]       r_outstanding;
    logic                  r_ovf_err;
    logic                  r_unexp_err;

    logic                  w_cmd_rd;
    logic                  w_dout_vd;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_push;
    logic                  w_owed;
    logic                  w_dec;
    logic [c_CW-1:0]       w_count_next;
    logic [c_CW-1:0]       w_out_next;
    logic [c_SW-1:0]       w_credit_sum;

    // Handshake and bookkeeping terms. A push is allowed into a full ring
    // only when the head leaves in the same cycle, which keeps the count flat.
    always_comb begin
        w_cmd_rd     = app_af_wren && (app_af_cmd == READ_CMD);
        w_dout_vd    = (r_count != '0);
        w_pop        = w_dout_vd && dout_rdy;
        w_full       = (r_count == c_DEPTH);
        w_push       = rd_data_valid && (!w_full || w_pop);
        w_owed       = (r_outstanding != '0);
        // A returned word retires one owed word even if it is dropped;
        // stray words with nothing owed leave the counter at zero.
        w_dec        = rd_data_valid && w_owed;
        w_count_next = r_count + c_CW'(w_push) - c_CW'(w_pop);
        w_out_next   = r_outstanding + (w_cmd_rd ? c_BURST : '0) - c_CW'(w_dec);
        w_credit_sum = {1'b0, r_count} + {1'b0, r_outstanding};
    end

    // Credit is a function of registered state plus reset and calibration
    // status only, so a command accepted this cycle is reflected next cycle.
    always_comb begin
        rd_en = !reset && phy_init_done && (w_credit_sum <= c_LIMIT);
    end

    // Head word presented combinationally; forced to zero while empty.
    always_comb begin
        dout_vd     = w_dout_vd;
        dout        = w_dout_vd ? r_mem[r_rd_ptr] : '0;
        outstanding = r_outstanding;
        ovf_err     = r_ovf_err;
        unexp_err   = r_unexp_err;
    end

    // Ring data write; contents need no reset because count gates the head.
    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rd_data_fifo_out;
        end
    end

    // Pointers, occupancy, owed-word tracking and sticky error flags.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_ovf_err     <= 1'b0;
            r_unexp_err   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count       <= w_count_next;
            r_outstanding <= w_out_next;
            if (rd_data_valid && w_full && !w_pop) begin
                r_ovf_err <= 1'b1;
            end
            if (rd_data_valid && !w_owed) begin
                r_unexp_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rd_data_collect.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rd_data_collect
//  Purpose  : Self-checking bench for rd_data_collect: a per-cycle vector
//             table plus hand-written fill / overflow / drain sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rd_data_collect;

    localparam int         c_DW    = 64;
    localparam logic [2:0] c_RD    = 3'b001;
    localparam int         c_NVEC  = 24;

    logic            sys_clk;
    logic            reset;
    logic            phy_init_done;
    logic            app_af_wren;
    logic [2:0]      app_af_cmd;
    logic            rd_data_valid;
    logic [c_DW-1:0] rd_data_fifo_out;
    logic            dout_rdy;
    logic            rd_en;
    logic [c_DW-1:0] dout;
    logic            dout_vd;
    logic [4:0]      outstanding;
    logic            ovf_err;
    logic            unexp_err;

    int n_checks = 0;
    int n_errors = 0;

    rd_data_collect #(
        .DATA_WIDTH  (c_DW),
        .BURST_WORDS (2),
        .DEPTH       (16),
        .READ_CMD    (c_RD)
    ) u_dut (
        .sys_clk          (sys_clk),
        .reset            (reset),
        .phy_init_done    (phy_init_done),
        .app_af_wren      (app_af_wren),
        .app_af_cmd       (app_af_cmd),
        .rd_data_valid    (rd_data_valid),
        .rd_data_fifo_out (rd_data_fifo_out),
        .dout_rdy         (dout_rdy),
        .rd_en            (rd_en),
        .dout             (dout),
        .dout_vd          (dout_vd),
        .outstanding      (outstanding),
        .ovf_err          (ovf_err),
        .unexp_err        (unexp_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Hard stop in case anything stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst;
        logic        phy;
        logic        wren;
        logic [2:0]  cmd;
        logic        vld;
        logic [63:0] din;
        logic        rdy;
        logic        e_rden;
        logic        e_vd;
        logic [63:0] e_dout;
        logic [4:0]  e_out;
        logic        e_ovf;
        logic        e_unexp;
    } vec_t;

    vec_t tbl [c_NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        app_af_wren      = 1'b0;
        app_af_cmd       = 3'b000;
        rd_data_valid    = 1'b0;
        rd_data_fifo_out = '0;
    endtask

    logic [63:0] exp_q [$];
    int          n_acc;

    initial begin
        //            rst phy wr cmd     vld din    rdy | rden vd dout   out ovf unx
        tbl[0]  = '{1'b1,1'b0,1'b0,3'b000,1'b0,64'h0 ,1'b0, 1'b0,1'b0,64'h0 ,5'd0,1'b0,1'b0};
        tbl[1]  = '{1'b0,1'b1,1'b0,3'b000,1'b0,64'h0 ,1'b0, 1'b1,1'b0,64'h0 ,5'd0,1'b0,1'b0};
        tbl[2]  = '{1'b0,1'b1,1'b1,c_RD  ,1'b0,64'h0 ,1'b1, 1'b1,1'b0,64'h0 ,5'd2,1'b0,1'b0};
        tbl[3]  = '{1'b0,1'b1,1'b0,3'b000,1'b1,64'hA1,1'b1, 1'b1,1'b1,64'hA1,5'd1,1'b0,1'b0};
        tbl[4]  = '{1'b0,1'b1,1'b0,3'b000,1'b1,64'hA2,1'b1, 1'b1,1'b1,64'hA2,5'd0,1'b0,1'b0};
        tbl[5]  = '{1'b0,1'b1,1'b0,3'b000,1'b0,64'h0 ,1'b1, 1'b1,1'b0,64'h0 ,5'd0,1'b0,1'b0};
        tbl[6]  = '{1'b0,1'b1,1'b1,3'b010,1'b0,64'h0 ,1'b1, 1'b1,1'b0,64'h0 ,5'd0,1'b0,1'b0};
        tbl[7]  = '{1'b0,1'b1,1'b0,3'b000,1'b1,64'hC0,1'b0, 1'b1,1'b1,64'hC0,5'd0,1'b0,1'b1};
        tbl[8]  = '{1'b0,1'b1,1'b0,3'b000,1'b0,64'h0 ,1'b1, 1'b1,1'b0,64'h0 ,5'd0,1'b0,1'b1};
        tbl[9]  = '{1'b0,1'b1,1'b1,c_RD  ,1'b0,64'h0 ,1'b0, 1'b1,1'b0,64'h0 ,5'd2,1'b0,1'b1};
        tbl[10] = '{1'b0,1'b1,1'b1,c_RD  ,1'b1,64'hB1,1'b0, 1'b1,1'b1,64'hB1,5'd3,1'b0,1'b1};
        tbl[11] = '{1'b0,1'b1,1'b0,3'b000,1'b1,64'hB2,1'b0, 1'b1,1'b1,64'hB1,5'd2,1'b0,1'b1};
        tbl[12] = '{1'b0,1'b1,1'b0,3'b000,1'b1,64'hB3,1'b0, 1'b1,1'b1,64'hB1,5'd1,1'b0,1'b1};
        tbl[13] = '{1'b0,1'b1,1'b1,c_RD  ,1'b1,64'hB4,1'b0, 1'b1,1'b1,64'hB1,5'd2,1'b0,1'b1};
        tbl[14] = '{1'b0,1'b1,1'b0,3'b000,1'b1,64'hB5,1'b0, 1'b1,1'b1,64'hB1,5'd1,1'b0,1'b1};
        tbl[15] = '{1'b0,1'b1,1'b0,3'b000,1'b1,64'hB6,1'b0, 1'b1,1'b1,64'hB1,5'd0,1'b0,1'b1};
        tbl[16] = '{1'b0,1'b0,1'b0,3'b000,1'b0,64'h0 ,1'b0, 1'b0,1'b1,64'hB1,5'd0,1'b0,1'b1};
        tbl[17] = '{1'b0,1'b1,1'b0,3'b000,1'b0,64'h0 ,1'b1, 1'b1,1'b1,64'hB2,5'd0,1'b0,1'b1};
        tbl[18] = '{1'b0,1'b1,1'b1,c_RD  ,1'b0,64'h0 ,1'b1, 1'b1,1'b1,64'hB3,5'd2,1'b0,1'b1};
        tbl[19] = '{1'b0,1'b1,1'b1,c_RD  ,1'b1,64'hB7,1'b0, 1'b1,1'b1,64'hB3,5'd3,1'b0,1'b1};
        tbl[20] = '{1'b1,1'b1,1'b0,3'b000,1'b0,64'h0 ,1'b0, 1'b0,1'b0,64'h0 ,5'd0,1'b0,1'b0};
        tbl[21] = '{1'b0,1'b1,1'b0,3'b000,1'b1,64'hD0,1'b0, 1'b1,1'b1,64'hD0,5'd0,1'b0,1'b1};
        tbl[22] = '{1'b1,1'b1,1'b0,3'b000,1'b0,64'h0 ,1'b0, 1'b0,1'b0,64'h0 ,5'd0,1'b0,1'b0};
        tbl[23] = '{1'b0,1'b1,1'b0,3'b000,1'b0,64'h0 ,1'b0, 1'b1,1'b0,64'h0 ,5'd0,1'b0,1'b0};

        reset         = 1'b1;
        phy_init_done = 1'b0;
        dout_rdy      = 1'b0;
        idle_inputs();

        // Table: drive on the falling edge, check just after the rising edge.
        for (int i = 0; i < c_NVEC; i++) begin
            @(negedge sys_clk);
            reset            = tbl[i].rst;
            phy_init_done    = tbl[i].phy;
            app_af_wren      = tbl[i].wren;
            app_af_cmd       = tbl[i].cmd;
            rd_data_valid    = tbl[i].vld;
            rd_data_fifo_out = tbl[i].din;
            dout_rdy         = tbl[i].rdy;
            @(posedge sys_clk);
            #1;
            chk($sformatf("row%0d rd_en", i),       64'(rd_en),       64'(tbl[i].e_rden));
            chk($sformatf("row%0d dout_vd", i),     64'(dout_vd),     64'(tbl[i].e_vd));
            chk($sformatf("row%0d dout", i),        dout,             tbl[i].e_dout);
            chk($sformatf("row%0d outstanding", i), 64'(outstanding), 64'(tbl[i].e_out));
            chk($sformatf("row%0d ovf_err", i),     64'(ovf_err),     64'(tbl[i].e_ovf));
            chk($sformatf("row%0d unexp_err", i),   64'(unexp_err),   64'(tbl[i].e_unexp));
        end

        // Fill: consumer stalled, issue read commands while credit allows.
        @(negedge sys_clk);
        idle_inputs();
        dout_rdy = 1'b0;
        n_acc    = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            if (!rd_en) break;
            app_af_wren = 1'b1;
            app_af_cmd  = c_RD;
            @(posedge sys_clk);
            #1;
            app_af_wren = 1'b0;
            app_af_cmd  = 3'b000;
            n_acc++;
        end
        chk("fill accepted cmds", 64'(n_acc), 64'd8);
        chk("fill rd_en low", 64'(rd_en), 64'd0);
        chk("fill outstanding", 64'(outstanding), 64'd16);

        // Return all sixteen owed words.
        for (int i = 0; i < 16; i++) begin
            @(negedge sys_clk);
            rd_data_valid    = 1'b1;
            rd_data_fifo_out = 64'h100 + 64'(i);
            exp_q.push_back(64'h100 + 64'(i));
            @(posedge sys_clk);
            #1;
            rd_data_valid = 1'b0;
        end
        chk("full outstanding", 64'(outstanding), 64'd0);
        chk("full ovf_err", 64'(ovf_err), 64'd0);
        chk("full unexp_err", 64'(unexp_err), 64'd0);
        chk("full rd_en", 64'(rd_en), 64'd0);
        chk("full head", dout, 64'h100);

        // Full ring with a simultaneous pop: word is kept, no overflow.
        @(negedge sys_clk);
        rd_data_valid    = 1'b1;
        rd_data_fifo_out = 64'hBEEF;
        dout_rdy         = 1'b1;
        void'(exp_q.pop_front());
        exp_q.push_back(64'hBEEF);
        @(posedge sys_clk);
        #1;
        rd_data_valid = 1'b0;
        dout_rdy      = 1'b0;
        chk("push+pop full ovf_err", 64'(ovf_err), 64'd0);
        chk("push+pop full head", dout, 64'h101);
        chk("push+pop full rd_en", 64'(rd_en), 64'd0);

        // Full ring, consumer stalled: word is dropped and flagged.
        @(negedge sys_clk);
        rd_data_valid    = 1'b1;
        rd_data_fifo_out = 64'hDEAD;
        @(posedge sys_clk);
        #1;
        rd_data_valid = 1'b0;
        chk("drop ovf_err", 64'(ovf_err), 64'd1);
        chk("drop unexp_err", 64'(unexp_err), 64'd1);
        chk("drop head", dout, 64'h101);

        // Drain: one word per cycle, in order, then empty.
        @(negedge sys_clk);
        dout_rdy = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("drain%0d vd", k), 64'(dout_vd), 64'd1);
            chk($sformatf("drain%0d dout", k), dout, exp_q[k]);
            @(negedge sys_clk);
        end
        chk("drain empty vd", 64'(dout_vd), 64'd0);
        chk("drain empty dout", dout, 64'd0);
        chk("drain rd_en", 64'(rd_en), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
